mult_div_seq: RTL and testbench

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

---
 rtl/mult_div_pkg.sv | 23 ++
 rtl/mult_div_step.sv | 34 +++
 rtl/mult_div_seq.sv | 137 +++++++++++++
 tb/tb_mult_div_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mult_div_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned CNT_W     = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIX,
      ST_DONE
   } state_t;

   // bit 1 selects divide, bit 0 selects unsigned
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module MulDivStep
   import mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] lo_w,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum      = {1'b0, acc} + {1'b0, (lo_w[0] ? operand : '0)};
      shifted  = {acc, lo_w[WIDTH-1]};
      ge       = (shifted >= {1'b0, operand});
      // the difference always fits in WIDTH bits whenever it is taken
      diff     = shifted[WIDTH-1:0] - operand;
      acc_next = sum[WIDTH:1];
      lo_next  = {sum[0], lo_w[WIDTH-1:1]};
      if (is_div) begin
         acc_next = ge ? diff : shifted[WIDTH-1:0];
         lo_next  = {lo_w[WIDTH-2:0], ge};
      end
   end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] oper_A,
   input  logic [WIDTH-1:0] oper_B,
   input  logic             abort,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   op_t                op_r;
   logic [WIDTH-1:0]   a_r, b_r, operand_r, acc, lo_w;
   logic [CNT_W-1:0]   cnt;
   logic               neg_lo, neg_hi;

   logic               is_signed;
   logic [WIDTH-1:0]   abs_a, abs_b, acc_next, lo_next, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;

   MulDivStep #(.WIDTH(WIDTH)) u_step (
      .is_div   (op_r[1]),
      .acc      (acc),
      .lo_w     (lo_w),
      .operand  (operand_r),
      .acc_next (acc_next),
      .lo_next  (lo_next)
   );

   // Magnitudes for PREP and sign-corrected results for FIX
   always_comb begin
      is_signed = ~op_r[0];
      abs_a     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
      abs_b     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
      prod      = {acc, lo_w};
      prod_fix  = neg_lo ? -prod : prod;
      res_hi    = prod_fix[2*WIDTH-1:WIDTH];
      res_lo    = prod_fix[WIDTH-1:0];
      if (op_r[1]) begin
         res_lo = neg_lo ? -lo_w : lo_w;
         res_hi = neg_hi ? -acc : acc;
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_r      <= OP_MULT;
         a_r       <= '0;
         b_r       <= '0;
         operand_r <= '0;
         acc       <= '0;
         lo_w      <= '0;
         cnt       <= '0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (state != ST_IDLE && abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (hi_write) hi <= wr_data;
                  if (lo_write) lo <= wr_data;
                  if (start && !abort) begin
                     op_r  <= op_t'(op);
                     a_r   <= oper_A;
                     b_r   <= oper_B;
                     state <= ST_PREP;
                     busy  <= 1'b1;
                  end
               end
               ST_PREP: begin
                  neg_lo    <= is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                  neg_hi    <= (op_r == OP_DIV) && a_r[WIDTH-1];
                  operand_r <= op_r[1] ? abs_b : abs_a;
                  lo_w      <= op_r[1] ? abs_a : abs_b;
                  acc       <= '0;
                  cnt       <= '0;
                  if (op_r[1] && b_r == '0) begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state <= ST_ITER;
                  end
               end
               ST_ITER: begin
                  acc  <= acc_next;
                  lo_w <= lo_next;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= ST_FIX;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_FIX: begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed, table-driven bench for mult_div_seq plus abort/reset/write corner sequences.
module tb_mult_div_seq;

   logic        Clk = 1'b0;
   logic        reset;
   logic        start, abort, hi_write, lo_write;
   logic [1:0]  op;
   logic [31:0] oper_A, oper_B, wr_data;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   mult_div_seq dut (
      .Clk      (Clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .oper_A   (oper_A),
      .oper_B   (oper_B),
      .abort    (abort),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
      logic        exp_dz;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, b,
                               input logic [31:0] ph, pl, eh, el, input logic dz);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.pre_hi = ph; v.pre_lo = pl;
      v.exp_hi = eh; v.exp_lo = el; v.exp_dz = dz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      hi_write = 1'b1; wr_data = h;
      step();
      hi_write = 1'b0; lo_write = 1'b1; wr_data = l;
      step();
      lo_write = 1'b0;
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; oper_A = a; oper_B = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Counts edges after the start edge until done; busy counted per sampled cycle
   task automatic wait_done(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 60) begin
         if (busy === 1'b1) bcnt++;
         step();
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt;
      logic saw;

      reset = 1'b1; start = 1'b0; abort = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
      op = 2'b00; oper_A = '0; oper_B = '0; wr_data = '0;

      #12;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dz", div_zero, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      @(negedge Clk);
      reset = 1'b0;
      step();

      vecs[0]  = mk(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      vecs[1]  = mk(2'b00, 32'hFFFFFFFD, 32'h7,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      vecs[2]  = mk(2'b10, 32'hFFFFFFF9, 32'h2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      vecs[3]  = mk(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h00000000, 32'h80000000, 1'b0);
      vecs[4]  = mk(2'b11, 32'd100,      32'h0,        32'h11, 32'h22, 32'h11,     32'h22,       1'b1);
      vecs[5]  = mk(2'b01, 32'h12345678, 32'h10,       32'h0, 32'h0, 32'h00000001, 32'h23456780, 1'b0);
      vecs[6]  = mk(2'b00, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 1'b0);
      vecs[7]  = mk(2'b00, 32'h80000000, 32'h1,        32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000, 1'b0);
      vecs[8]  = mk(2'b11, 32'hFFFFFFFF, 32'h10,       32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
      vecs[9]  = mk(2'b10, 32'h7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      vecs[10] = mk(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000003, 1'b0);
      vecs[11] = mk(2'b10, 32'h0,        32'h0,        32'h55, 32'h66, 32'h55,     32'h66,       1'b1);
      vecs[12] = mk(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000, 32'h00000000, 1'b0);
      vecs[13] = mk(2'b01, 32'h0,        32'h5,        32'h9, 32'h9, 32'h00000000, 32'h00000000, 1'b0);
      vecs[14] = mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h00000001, 1'b0);

      for (int i = 0; i < 15; i++) begin
         write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(lat, bcnt);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
         chk($sformatf("v%0d_dz", i), div_zero, vecs[i].exp_dz);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_dz ? 1 : 34);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_dz ? 1 : 34);
         step();
         chk($sformatf("v%0d_done_pulse", i), done, 0);
         chk($sformatf("v%0d_dz_low", i), div_zero, 0);
      end

      // Write strobes together with start: writes land, result later overwrites
      hi_write = 1'b1; lo_write = 1'b1; wr_data = 32'h77;
      launch(2'b01, 32'd3, 32'd5);
      hi_write = 1'b0; lo_write = 1'b0;
      chk("wr_start_hi", hi, 32'h77);
      chk("wr_start_lo", lo, 32'h77);
      chk("wr_start_busy", busy, 1);
      wait_done(lat, bcnt);
      chk("wr_start_lat", lat, 34);
      chk("wr_start_res_hi", hi, 0);
      chk("wr_start_res_lo", lo, 15);

      // Start during DONE is ignored
      op = 2'b01; oper_A = 32'd9; oper_B = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      chk("done_start_busy", busy, 0);
      step();
      chk("done_start_busy2", busy, 0);
      chk("done_start_lo", lo, 15);

      // Abort at ITER cycle 10
      write_hilo(32'h1111, 32'h2222);
      launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (11) step();
      chk("abort_busy_before", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy_after", busy, 0);
      saw = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
         step();
      end
      chk("abort_no_done", saw, 0);
      chk("abort_hi", hi, 32'h1111);
      chk("abort_lo", lo, 32'h2222);

      // hi_write while busy is ignored; in IDLE it applies
      launch(2'b01, 32'd4, 32'd4);
      repeat (3) step();
      hi_write = 1'b1; wr_data = 32'hABCD;
      step();
      hi_write = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("busy_write_ignored", hi, 32'h1111);
      hi_write = 1'b1; wr_data = 32'hABCD;
      step();
      hi_write = 1'b0;
      chk("idle_write_hi", hi, 32'hABCD);
      chk("idle_write_lo_kept", lo, 32'h2222);

      // abort and start together in IDLE
      abort = 1'b1;
      launch(2'b00, 32'd2, 32'd2);
      abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      step();
      chk("abort_start_done", done, 0);

      // Asynchronous reset at ITER cycle 5
      write_hilo(32'h33, 32'h44);
      launch(2'b01, 32'd5, 32'd5);
      repeat (6) step();
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_dz", div_zero, 0);
      chk("rst_mid_hi", hi, 0);
      chk("rst_mid_lo", lo, 0);
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
      end
      chk("rst_release_no_done", saw, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
